// File: rtl/inst_fetch_queue_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue_if
//   Bundles every signal that crosses the boundary of the IF-stage instruction
//   queue: the PC-side request, the pipeline stall/flush controls, the
//   instruction ROM port and the registered IF/ID output pair.
//
//   Modports
//     master : the surrounding pipeline (PC register, stall controller, ROM,
//              decode). It drives pc/ce/stall/flush/rom_data and observes the
//              rest.
//     slave  : inst_fetch_queue itself.
//
//   Signals
//     pc         ADDR_W  fetch address from PC register
//     ce         1       PC chip-enable; 1 = pc valid
//     stall      6       pipeline stall vector; [0]=IF frozen, [1]=ID frozen
//     flush      1       discard queue, in-flight fetch and ID output
//     rom_ce     1       instruction ROM read enable
//     rom_addr   ADDR_W  instruction ROM address
//     rom_data   DATA_W  ROM data, valid the cycle after rom_ce=1
//     id_pc      ADDR_W  PC of instruction handed to decode
//     id_inst    DATA_W  instruction handed to decode; 0 = bubble (nop)
//     fetch_full 1       request to stall IF
//     q_ovf      1       sticky: push attempted while queue full
// -----------------------------------------------------------------------------
interface inst_fetch_queue_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);

   logic [ADDR_W-1:0] pc;
   logic              ce;
   logic [5:0]        stall;
   logic              flush;
   logic              rom_ce;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data;
   logic [ADDR_W-1:0] id_pc;
   logic [DATA_W-1:0] id_inst;
   logic              fetch_full;
   logic              q_ovf;

   modport master (
      output pc, ce, stall, flush, rom_data,
      input  rom_ce, rom_addr, id_pc, id_inst, fetch_full, q_ovf
   );

   modport slave (
      input  pc, ce, stall, flush, rom_data,
      output rom_ce, rom_addr, id_pc, id_inst, fetch_full, q_ovf
   );

endinterface

// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
//   IF-stage instruction queue sitting directly downstream of the PC register.
//   Each cycle the PC is valid and IF is not frozen, a read is issued to the
//   synchronous instruction ROM (one cycle of read latency). The returned
//   {pc, inst} pair is buffered in a DEPTH-entry FIFO and handed to decode as a
//   registered IF/ID pair. fetch_full asks the stall controller to freeze the
//   PC while there is still one entry of slack for the read already issued.
//
//   Parameters
//     ADDR_W  instruction address width
//     DATA_W  instruction word width
//     DEPTH   queue entries; power of two, >= 2
//
//   Ports
//     clk    clock
//     rst    synchronous reset, active-high
//     io_fq  inst_fetch_queue_if.slave (pc/ce/stall/flush in, ROM port,
//            id_pc/id_inst out, fetch_full, q_ovf)
//
//   Build option
//     FETCHQ_BYPASS_EN  when defined, a word returning from the ROM while the
//                       queue is empty and decode is accepting goes straight
//                       to id_pc/id_inst (pc -> id_inst in 2 cycles). When
//                       undefined, every word passes through the queue
//                       (3 cycles). The fetch_full threshold is identical.
// -----------------------------------------------------------------------------
module inst_fetch_queue #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   inst_fetch_queue_if.slave io_fq
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int OCC_W = CNT_W + 1;

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [OCC_W-1:0] OCC_THR  = OCC_W'(DEPTH - 1);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic              r_rst_q;        // high during the first cycle after reset
   logic              r_inflight;     // a ROM read was issued last cycle
   logic [ADDR_W-1:0] r_inflight_pc;  // pc of that read

   logic [ADDR_W-1:0] r_mem_pc   [DEPTH];
   logic [DATA_W-1:0] r_mem_inst [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;

   logic [ADDR_W-1:0] r_id_pc;
   logic [DATA_W-1:0] r_id_inst;
   logic              r_ovf;

   // ---------------------------------------------------------------------------
   // Control
   // ---------------------------------------------------------------------------
   logic              w_issue;
   logic              w_arrive;
   logic              w_id_ready;
   logic              w_empty;
   logic              w_full;
   logic              w_pop;
   logic              w_bypass;
   logic              w_push;
   logic              w_write;
   logic              w_drop;
   logic [CNT_W-1:0]  w_count_nxt;
   logic [OCC_W-1:0]  w_occupancy;
   logic [ADDR_W-1:0] w_head_pc;
   logic [DATA_W-1:0] w_head_inst;
   logic              w_unused_stall;

   // Reads are held off for one extra cycle after reset so the ROM never sees
   // a request issued against state that was only just cleared.
   assign w_issue    = io_fq.ce & ~io_fq.stall[0] & ~rst & ~r_rst_q;

   // ROM data returning this cycle is only kept if no flush is under way.
   assign w_arrive   = r_inflight & ~io_fq.flush;
   assign w_id_ready = ~io_fq.stall[1];
   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == CNT_FULL);
   assign w_pop      = w_id_ready & ~w_empty;

`ifdef FETCHQ_BYPASS_EN
   // Bypass only with an empty queue, so issue order is never violated.
   assign w_bypass   = w_arrive & w_empty & w_id_ready;
`else
   assign w_bypass   = 1'b0;
`endif

   assign w_push     = w_arrive & ~w_bypass;
   // A full queue still accepts a push when the head leaves in the same cycle:
   // the freed slot is the one being written.
   assign w_write    = w_push & (~w_full | w_pop);
   assign w_drop     = w_push & w_full & ~w_pop;

   assign w_head_pc   = r_mem_pc[r_rd_ptr];
   assign w_head_inst = r_mem_inst[r_rd_ptr];

   always_comb begin
      // NOTE: combinational blocks assign a default first so no path can leave
      // the signal unassigned and infer a latch.
      w_count_nxt = r_count;
      case ({w_write, w_pop})
         2'b10:   w_count_nxt = r_count + CNT_W'(1);
         2'b01:   w_count_nxt = r_count - CNT_W'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   // Occupancy counts the read under way so the PC freezes while one entry of
   // slack remains for it.
   assign w_occupancy = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};

   // Stall bits above ID belong to later stages and are not used here.
   assign w_unused_stall = ^io_fq.stall[5:2];

   // ---------------------------------------------------------------------------
   // Sequential logic
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (rst) begin
         r_rst_q       <= 1'b1;
         r_inflight    <= 1'b0;
         r_inflight_pc <= '0;
      end else begin
         r_rst_q       <= 1'b0;
         r_inflight    <= w_issue & ~io_fq.flush;
         if (w_issue) begin
            r_inflight_pc <= io_fq.pc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || io_fq.flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         // Pointers wrap naturally because DEPTH is a power of two.
         if (w_write) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         r_count <= w_count_nxt;
      end
   end

   // NOTE: the storage array has no reset; entries are only ever read when
   // r_count says they were written, so their power-up value is irrelevant.
   always_ff @(posedge clk) begin
      if (w_write) begin
         r_mem_pc[r_wr_ptr]   <= r_inflight_pc;
         r_mem_inst[r_wr_ptr] <= io_fq.rom_data;
      end
   end

   // IF/ID pair: flush wins over a frozen ID stage.
   always_ff @(posedge clk) begin
      if (rst || io_fq.flush) begin
         r_id_pc   <= '0;
         r_id_inst <= '0;
      end else if (w_id_ready) begin
         if (w_pop) begin
            r_id_pc   <= w_head_pc;
            r_id_inst <= w_head_inst;
         end else if (w_bypass) begin
            r_id_pc   <= r_inflight_pc;
            r_id_inst <= io_fq.rom_data;
         end else begin
            r_id_pc   <= '0;
            r_id_inst <= '0;
         end
      end
   end

   // Overflow is sticky until reset; flush does not clear it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (w_drop) begin
         r_ovf <= 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign io_fq.rom_ce     = w_issue;
   assign io_fq.rom_addr   = io_fq.pc;
   assign io_fq.id_pc      = r_id_pc;
   assign io_fq.id_inst    = r_id_inst;
   assign io_fq.fetch_full = ~rst & (w_occupancy >= OCC_THR);
   assign io_fq.q_ovf      = r_ovf;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_queue
//   Directed bench for inst_fetch_queue (DEPTH=4). A behavioural one-cycle
//   ROM answers reads; each scenario task drives stimulus and compares the
//   IF/ID outputs against hand-derived values. Inputs change 1 ns after the
//   rising edge and outputs are sampled at that same point.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_inst_fetch_queue;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 4;
`ifdef FETCHQ_BYPASS_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 3;
`endif

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   inst_fetch_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) fq ();

   inst_fetch_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .io_fq (fq)
   );

   always #5 clk = ~clk;

   // ROM contents: pc 0,4,8,C hold 0x11,0x22,0x33,0x44; elsewhere C0DE_0000|pc.
   function automatic logic [31:0] rom_word(input logic [31:0] a);
      if (a < 32'h10) return 32'h11 * (32'(a[3:2]) + 32'd1);
      return 32'hC0DE_0000 | a;
   endfunction

   always @(posedge clk) begin
      if (fq.rom_ce) fq.rom_data <= rom_word(fq.rom_addr);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      fq.ce    = 1'b0;
      fq.pc    = '0;
      fq.stall = '0;
      fq.flush = 1'b0;
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      fq.ce    = 1'b1;
      fq.pc    = 32'h40;
      fq.stall = '0;
      fq.flush = 1'b0;
      repeat (3) step();
      checks++; if (fq.rom_ce !== 1'b0) begin errors++; $display("FAIL reset rom_ce: got %b expected 0", fq.rom_ce); end
      checks++; if (fq.id_inst !== 32'h0) begin errors++; $display("FAIL reset id_inst: got %h expected 0", fq.id_inst); end
      checks++; if (fq.id_pc !== 32'h0) begin errors++; $display("FAIL reset id_pc: got %h expected 0", fq.id_pc); end
      checks++; if (fq.fetch_full !== 1'b0) begin errors++; $display("FAIL reset fetch_full: got %b expected 0", fq.fetch_full); end
      checks++; if (fq.q_ovf !== 1'b0) begin errors++; $display("FAIL reset q_ovf: got %b expected 0", fq.q_ovf); end
      rst = 1'b0;
      #1;
      checks++; if (fq.rom_ce !== 1'b0) begin errors++; $display("FAIL post_reset rom_ce: got %b expected 0", fq.rom_ce); end
      checks++; if (fq.fetch_full !== 1'b0) begin errors++; $display("FAIL post_reset fetch_full: got %b expected 0", fq.fetch_full); end
      fq.ce = 1'b0;
      step();
      // Momentary enables between edges: only the combinational issue path moves.
      fq.ce = 1'b1;
      #1;
      checks++; if (fq.rom_ce !== 1'b1) begin errors++; $display("FAIL issue rom_ce: got %b expected 1", fq.rom_ce); end
      checks++; if (fq.rom_addr !== 32'h40) begin errors++; $display("FAIL issue rom_addr: got %h expected 00000040", fq.rom_addr); end
      fq.stall = 6'b000001;
      #1;
      checks++; if (fq.rom_ce !== 1'b0) begin errors++; $display("FAIL if_stall rom_ce: got %b expected 0", fq.rom_ce); end
      idle();
      #1;
   endtask

   task automatic test_stream();
      logic [31:0] exp_inst [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
      logic [31:0] exp_pc   [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
      logic [31:0] e_inst, e_pc;
      int idx;
      for (int k = 0; k < 9; k++) begin
         fq.ce = (k < 4);
         fq.pc = (k < 4) ? 32'(4 * k) : 32'h0;
         step();
         idx    = k + 1 - LAT;
         e_inst = (idx >= 0 && idx < 4) ? exp_inst[idx] : 32'h0;
         e_pc   = (idx >= 0 && idx < 4) ? exp_pc[idx]   : 32'h0;
         checks++; if (fq.id_inst !== e_inst) begin errors++; $display("FAIL stream[%0d] id_inst: got %h expected %h", k + 1, fq.id_inst, e_inst); end
         checks++; if (fq.id_pc !== e_pc) begin errors++; $display("FAIL stream[%0d] id_pc: got %h expected %h", k + 1, fq.id_pc, e_pc); end
      end
      idle();
   endtask

   task automatic test_backpressure();
      int issued   = 0;
      int first_ff = -1;
      logic [31:0] e;
      for (int c = 0; c < 8; c++) begin
         fq.stall = {4'b0, 1'b1, fq.fetch_full};
         if (fq.fetch_full && first_ff < 0) first_ff = c;
         if (!fq.fetch_full) begin
            fq.ce = 1'b1;
            fq.pc = 32'h20 + 32'(4 * issued);
            issued++;
         end else begin
            fq.ce = 1'b0;
         end
         step();
         checks++; if (fq.id_inst !== 32'h0) begin errors++; $display("FAIL bp_hold[%0d] id_inst: got %h expected 0", c, fq.id_inst); end
      end
      checks++; if (first_ff !== 3) begin errors++; $display("FAIL bp fetch_full first cycle: got %0d expected 3", first_ff); end
      checks++; if (issued !== 3) begin errors++; $display("FAIL bp issued: got %0d expected 3", issued); end
      checks++; if (fq.q_ovf !== 1'b0) begin errors++; $display("FAIL bp q_ovf: got %b expected 0", fq.q_ovf); end
      idle();
      for (int j = 0; j < 4; j++) begin
         step();
         e = (j < 3) ? rom_word(32'h20 + 32'(4 * j)) : 32'h0;
         checks++; if (fq.id_inst !== e) begin errors++; $display("FAIL bp_drain[%0d] id_inst: got %h expected %h", j, fq.id_inst, e); end
      end
   endtask

   task automatic test_flush();
      fq.ce = 1'b1;
      fq.pc = 32'h3C;
      step();
      fq.ce = 1'b0;
      repeat (LAT - 1) step();
      checks++; if (fq.id_inst !== rom_word(32'h3C)) begin errors++; $display("FAIL flush_pre id_inst: got %h expected %h", fq.id_inst, rom_word(32'h3C)); end
      fq.stall = 6'b000010;
      for (int i = 0; i < 4; i++) begin
         fq.ce = 1'b1;
         fq.pc = 32'h40 + 32'(4 * i);
         step();
      end
      checks++; if (fq.fetch_full !== 1'b1) begin errors++; $display("FAIL flush_pre fetch_full: got %b expected 1", fq.fetch_full); end
      checks++; if (fq.id_inst !== rom_word(32'h3C)) begin errors++; $display("FAIL flush_hold id_inst: got %h expected %h", fq.id_inst, rom_word(32'h3C)); end
      // Flush with ID frozen and a new read issued in the same cycle.
      fq.flush = 1'b1;
      fq.pc    = 32'h50;
      step();
      idle();
      checks++; if (fq.id_inst !== 32'h0) begin errors++; $display("FAIL flush id_inst: got %h expected 0", fq.id_inst); end
      checks++; if (fq.id_pc !== 32'h0) begin errors++; $display("FAIL flush id_pc: got %h expected 0", fq.id_pc); end
      checks++; if (fq.fetch_full !== 1'b0) begin errors++; $display("FAIL flush fetch_full: got %b expected 0", fq.fetch_full); end
      step();
      checks++; if (fq.id_inst !== 32'h0) begin errors++; $display("FAIL flush_stale id_inst: got %h expected 0", fq.id_inst); end
      fq.ce = 1'b1;
      fq.pc = 32'h100;
      for (int k = 1; k <= LAT + 1; k++) begin
         step();
         fq.ce = 1'b0;
         if (k == LAT) begin
            checks++; if (fq.id_inst !== rom_word(32'h100)) begin errors++; $display("FAIL flush_new id_inst: got %h expected %h", fq.id_inst, rom_word(32'h100)); end
            checks++; if (fq.id_pc !== 32'h100) begin errors++; $display("FAIL flush_new id_pc: got %h expected 00000100", fq.id_pc); end
         end else begin
            checks++; if (fq.id_inst !== 32'h0) begin errors++; $display("FAIL flush_gap[%0d] id_inst: got %h expected 0", k, fq.id_inst); end
         end
      end
      idle();
   endtask

   task automatic test_overflow();
      logic [31:0] e_inst, e_pc;
      fq.stall = 6'b000010;
      for (int i = 0; i < 6; i++) begin
         fq.ce = 1'b1;
         fq.pc = 32'h200 + 32'(4 * i);
         step();
         if (i == 4) begin
            checks++; if (fq.q_ovf !== 1'b0) begin errors++; $display("FAIL ovf_4push q_ovf: got %b expected 0", fq.q_ovf); end
         end
         if (i == 5) begin
            checks++; if (fq.q_ovf !== 1'b1) begin errors++; $display("FAIL ovf_5push q_ovf: got %b expected 1", fq.q_ovf); end
         end
      end
      fq.ce = 1'b0;
      step();
      idle();
      for (int j = 0; j < 5; j++) begin
         step();
         e_inst = (j < 4) ? rom_word(32'h200 + 32'(4 * j)) : 32'h0;
         e_pc   = (j < 4) ? 32'h200 + 32'(4 * j) : 32'h0;
         checks++; if (fq.id_inst !== e_inst) begin errors++; $display("FAIL ovf_drain[%0d] id_inst: got %h expected %h", j, fq.id_inst, e_inst); end
         checks++; if (fq.id_pc !== e_pc) begin errors++; $display("FAIL ovf_drain[%0d] id_pc: got %h expected %h", j, fq.id_pc, e_pc); end
      end
      checks++; if (fq.q_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky q_ovf: got %b expected 1", fq.q_ovf); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if (fq.q_ovf !== 1'b0) begin errors++; $display("FAIL ovf_reset q_ovf: got %b expected 0", fq.q_ovf); end
      step();
   endtask

   task automatic test_full_push_pop();
      logic [31:0] e_inst, e_pc;
      int idx;
      for (int c = 0; c < 19; c++) begin
         fq.ce    = (c < 12);
         fq.pc    = (c < 12) ? 32'h300 + 32'(4 * c) : 32'h0;
         fq.stall = (c < 5) ? 6'b000010 : 6'b000000;
         if (c == 5) begin
            checks++; if (fq.fetch_full !== 1'b1) begin errors++; $display("FAIL full fetch_full: got %b expected 1", fq.fetch_full); end
         end
         step();
         idx    = c + 1 - 6;
         e_inst = (idx >= 0 && idx < 12) ? rom_word(32'h300 + 32'(4 * idx)) : 32'h0;
         e_pc   = (idx >= 0 && idx < 12) ? 32'h300 + 32'(4 * idx) : 32'h0;
         checks++; if (fq.id_inst !== e_inst) begin errors++; $display("FAIL full[%0d] id_inst: got %h expected %h", c + 1, fq.id_inst, e_inst); end
         checks++; if (fq.id_pc !== e_pc) begin errors++; $display("FAIL full[%0d] id_pc: got %h expected %h", c + 1, fq.id_pc, e_pc); end
      end
      checks++; if (fq.q_ovf !== 1'b0) begin errors++; $display("FAIL full q_ovf: got %b expected 0", fq.q_ovf); end
      idle();
   endtask

   initial begin
      fq.rom_data = '0;
      idle();
      rst = 1'b1;
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_overflow();
      test_full_push_pop();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
